// File: rtl/sbd_shifter_seq.sv
// sbd_shifter_seq: WIDTH-bit shift register with a sequenced multi-step
// shift (START/BUSY/DONE) and a single-step SHIFT for legacy callers.
// Optional feature: define SBD_SHIFTER_ROTATE_EN to honour rot_i (rotate
// instead of filling from sin_i). Without it rot_i is accepted but ignored.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a command (LOAD > START > SHIFT)
// RUN   | sequenced shift in progress, one shift per cycle
// FIN   | sequence complete, DONE high, commands accepted as in IDLE
module sbd_shifter_seq #(
   parameter int WIDTH = 24,
   parameter int STEP  = 2,
   parameter int CNTW  = 5
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] pin_i,
   input  logic             shift_i,
   input  logic             start_i,
   input  logic [CNTW-1:0]  cnt_i,
   input  logic             dir_i,
   input  logic             rot_i,
   input  logic [STEP-1:0]  sin_i,
   output logic [WIDTH-1:0] pout_o,
   output logic [STEP-1:0]  sout_o,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] reg_q, reg_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             dir_eff;
   logic             rot_eff;
   logic             seq_go;
   logic [STEP-1:0]  fill_l, fill_r;
   logic [WIDTH-1:0] shifted;

   // a START that will actually launch a sequence this cycle
   assign seq_go  = (state_q != S_RUN) && !load_i && start_i && (cnt_i != '0);
   assign dir_eff = (state_q == S_RUN) ? dir_q : dir_i;

`ifdef SBD_SHIFTER_ROTATE_EN
   logic rot_q;

   assign rot_eff = (state_q == S_RUN) ? rot_q : rot_i;

   // rotate mode is latched alongside direction when a sequence launches
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)    rot_q <= 1'b0;
      else if (seq_go) rot_q <= rot_i;
   end
`else
   logic unused_rot;

   assign unused_rot = rot_i;
   assign rot_eff    = 1'b0;
`endif

   // one-step shift of the register in the effective direction
   always_comb begin
      fill_l = sin_i;
      fill_r = sin_i;
      if (rot_eff) begin
         fill_l = reg_q[WIDTH-1:WIDTH-STEP];
         fill_r = reg_q[STEP-1:0];
      end
      if (dir_eff) shifted = {fill_r, reg_q[WIDTH-1:STEP]};
      else         shifted = {reg_q[WIDTH-STEP-1:0], fill_l};
   end

   // state and datapath registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         reg_q   <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         reg_q   <= reg_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
      end
   end

   // next-state and datapath update
   always_comb begin
      state_d = state_q;
      reg_d   = reg_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      case (state_q)
         S_RUN: begin
            if (load_i) begin
               // abort: no DONE for an interrupted sequence
               reg_d   = pin_i;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               reg_d = shifted;
               if (cnt_q != '0) cnt_d = cnt_q - CNTW'(1);
               if (cnt_q <= CNTW'(1)) state_d = S_FIN;
            end
         end
         default: begin
            state_d = S_IDLE;
            if (load_i) begin
               reg_d = pin_i;
            end else if (start_i) begin
               if (cnt_i != '0) begin
                  cnt_d   = cnt_i;
                  dir_d   = dir_i;
                  state_d = S_RUN;
               end else begin
                  state_d = S_FIN;
               end
            end else if (shift_i) begin
               reg_d = shifted;
            end
         end
      endcase
   end

   // outputs decoded from state and register
   always_comb begin
      busy_o = (state_q == S_RUN);
      done_o = (state_q == S_FIN);
      pout_o = reg_q;
      sout_o = dir_eff ? reg_q[STEP-1:0] : reg_q[WIDTH-1:WIDTH-STEP];
   end

endmodule

// File: tb/tb_sbd_shifter_seq.sv
// Self-checking bench for sbd_shifter_seq at WIDTH=8, STEP=2, CNTW=5.
module tb_sbd_shifter_seq;

`ifdef SBD_SHIFTER_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load, shift, start, dir, rot;
   logic [7:0] pin;
   logic [4:0] cnt;
   logic [1:0] sin;
   logic [7:0] pout;
   logic [1:0] sout;
   logic       busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   sbd_shifter_seq #(.WIDTH(8), .STEP(2), .CNTW(5)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .load_i(load), .pin_i(pin),
      .shift_i(shift), .start_i(start), .cnt_i(cnt), .dir_i(dir),
      .rot_i(rot), .sin_i(sin), .pout_o(pout), .sout_o(sout),
      .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      load = 0; shift = 0; start = 0; dir = 0; rot = 0;
      pin = 8'h00; cnt = 5'd0; sin = 2'b00;
   endtask

   // reference: one step of the shift rule, in plain integer arithmetic
   function automatic logic [7:0] mshift(input logic [7:0] r, input logic d,
                                         input logic ro, input logic [1:0] s);
      int v, f;
      v = int'(r);
      f = int'(s);
      if (ro && ROT_EN) f = d ? v % 4 : v / 64;
      if (d) return 8'((v / 4) + f * 64);
      else   return 8'((v * 4 + f) % 256);
   endfunction

   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      tick(); tick();
      n_checks++; if (pout !== 8'h00) begin n_fail++; $display("FAIL reset_pout got %h exp 00", pout); end
      n_checks++; if (sout !== 2'b00) begin n_fail++; $display("FAIL reset_sout got %b exp 00", sout); end
      n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
      #3 rst_n = 1;
      tick();
   endtask

   task automatic test_left_seq();
      load = 1; pin = 8'hA5; tick(); load = 0;
      n_checks++; if (sout !== 2'b10) begin n_fail++; $display("FAIL left_sout0 got %b exp 10", sout); end
      start = 1; dir = 0; cnt = 5'd2; sin = 2'b01;
      tick();
      start = 0; dir = 1;   // latched direction must hold
      #1;
      n_checks++; if (busy !== 1'b1 || pout !== 8'hA5 || sout !== 2'b10) begin n_fail++;
         $display("FAIL left_c1 got busy=%b pout=%h sout=%b exp 1 a5 10", busy, pout, sout); end
      tick();
      n_checks++; if (busy !== 1'b1 || pout !== 8'h95 || sout !== 2'b10) begin n_fail++;
         $display("FAIL left_c2 got busy=%b pout=%h sout=%b exp 1 95 10", busy, pout, sout); end
      dir = 0;
      tick();
      n_checks++; if (busy !== 1'b0 || done !== 1'b1 || pout !== 8'h55 || sout !== 2'b01) begin n_fail++;
         $display("FAIL left_c3 got busy=%b done=%b pout=%h sout=%b exp 0 1 55 01", busy, done, pout, sout); end
      tick();
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL left_done_pulse got %b exp 0", done); end
   endtask

   task automatic test_right_seq();
      load = 1; pin = 8'hA5; tick(); load = 0;
      start = 1; dir = 1; cnt = 5'd1; sin = 2'b11;
      #1;
      n_checks++; if (sout !== 2'b01) begin n_fail++; $display("FAIL right_sout0 got %b exp 01", sout); end
      tick(); start = 0;
      n_checks++; if (busy !== 1'b1 || pout !== 8'hA5) begin n_fail++;
         $display("FAIL right_c1 got busy=%b pout=%h exp 1 a5", busy, pout); end
      tick();
      n_checks++; if (done !== 1'b1 || busy !== 1'b0 || pout !== 8'hE9) begin n_fail++;
         $display("FAIL right_c2 got done=%b busy=%b pout=%h exp 1 0 e9", done, busy, pout); end
   endtask

   task automatic test_zero_count();
      idle_inputs(); tick();
      start = 1; cnt = 5'd0;
      tick();
      n_checks++; if (done !== 1'b1 || busy !== 1'b0 || pout !== 8'hE9) begin n_fail++;
         $display("FAIL zero_c1 got done=%b busy=%b pout=%h exp 1 0 e9", done, busy, pout); end
      start = 1; cnt = 5'd1; dir = 0; sin = 2'b00;   // back-to-back in DONE cycle
      tick(); start = 0;
      n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++;
         $display("FAIL zero_b2b got busy=%b done=%b exp 1 0", busy, done); end
      tick();
      n_checks++; if (done !== 1'b1 || pout !== 8'hA4) begin n_fail++;
         $display("FAIL zero_b2b_end got done=%b pout=%h exp 1 a4", done, pout); end
   endtask

   task automatic test_abort();
      idle_inputs();
      load = 1; pin = 8'h0F; tick(); load = 0;
      start = 1; dir = 0; cnt = 5'd10; tick(); start = 0;
      tick(); tick();
      load = 1; pin = 8'h3C; tick(); load = 0;
      n_checks++; if (pout !== 8'h3C || busy !== 1'b0 || done !== 1'b0) begin n_fail++;
         $display("FAIL abort got pout=%h busy=%b done=%b exp 3c 0 0", pout, busy, done); end
      tick();
      n_checks++; if (done !== 1'b0 || pout !== 8'h3C) begin n_fail++;
         $display("FAIL abort_after got done=%b pout=%h exp 0 3c", done, pout); end
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      load = 1; pin = 8'hC3; tick(); load = 0;
      start = 1; cnt = 5'd10; tick(); start = 0;
      tick();
      #2 rst_n = 0;
      #1;
      n_checks++; if (pout !== 8'h00 || sout !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin n_fail++;
         $display("FAIL reset_mid got pout=%h sout=%b busy=%b done=%b exp 0", pout, sout, busy, done); end
      #1 rst_n = 1;
      tick();
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++;
         $display("FAIL reset_mid_after got busy=%b done=%b exp 0 0", busy, done); end
   endtask

   task automatic test_shift_busy();
      idle_inputs();
      load = 1; pin = 8'h81; tick(); load = 0;
      start = 1; dir = 1; cnt = 5'd2; tick();
      shift = 1; start = 1;
      tick(); tick();
      shift = 0; start = 0;
      n_checks++; if (done !== 1'b1 || pout !== 8'h08) begin n_fail++;
         $display("FAIL shift_busy got done=%b pout=%h exp 1 08", done, pout); end
      dir = 0; sin = 2'b10; shift = 1; tick(); shift = 0;
      n_checks++; if (pout !== 8'h22 || busy !== 1'b0 || done !== 1'b0) begin n_fail++;
         $display("FAIL single_shift got pout=%h busy=%b done=%b exp 22 0 0", pout, busy, done); end
   endtask

   task automatic test_rotate();
      logic [7:0] exp_v;
      idle_inputs();
      load = 1; pin = 8'hA5; tick(); load = 0;
      start = 1; rot = 1; dir = 0; cnt = 5'd4; sin = 2'b00; tick();
      start = 0; rot = 0;
      for (int i = 0; i < 4; i++) tick();
      exp_v = ROT_EN ? 8'hA5 : 8'h00;
      n_checks++; if (done !== 1'b1 || pout !== exp_v) begin n_fail++;
         $display("FAIL rot_left got done=%b pout=%h exp 1 %h", done, pout, exp_v); end
      load = 1; pin = 8'hA5; tick(); load = 0;
      start = 1; rot = 1; dir = 1; cnt = 5'd1; tick();
      start = 0; rot = 0; tick();
      exp_v = ROT_EN ? 8'h69 : 8'h29;
      n_checks++; if (done !== 1'b1 || pout !== exp_v) begin n_fail++;
         $display("FAIL rot_right got done=%b pout=%h exp 1 %h", done, pout, exp_v); end
      load = 1; pin = 8'hA5; tick(); load = 0;
      shift = 1; rot = 1; dir = 0; tick(); shift = 0; rot = 0;
      exp_v = ROT_EN ? 8'h96 : 8'h94;
      n_checks++; if (pout !== exp_v) begin n_fail++;
         $display("FAIL rot_shift got pout=%h exp %h", pout, exp_v); end
   endtask

   task automatic test_max_count();
      int nbusy;
      bit seen;
      idle_inputs();
      nbusy = 0; seen = 0;
      load = 1; pin = 8'h01; tick(); load = 0;
      start = 1; cnt = 5'd31; dir = 1; tick(); start = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (busy) nbusy++;
         if (done) seen = 1;
         else tick();
      end
      n_checks++; if (!seen || nbusy != 31) begin n_fail++;
         $display("FAIL max_count got done_seen=%0d busy_cycles=%0d exp 1 31", seen, nbusy); end
   endtask

   task automatic test_random();
      logic [7:0] m_reg, exp_p;
      logic [1:0] exp_s;
      logic       m_dir, m_rot, m_done, eff;
      int         m_left;
      idle_inputs();
      #2 rst_n = 0;
      #2 rst_n = 1;
      m_reg = 8'h00; m_left = 0; m_dir = 0; m_rot = 0; m_done = 0;
      tick();
      for (int i = 0; i < 400; i++) begin
         load  = ($urandom_range(15) == 0);
         start = ($urandom_range(4) == 0);
         shift = ($urandom_range(2) == 0);
         cnt   = ($urandom_range(7) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(4));
         dir   = 1'($urandom_range(1));
         rot   = 1'($urandom_range(1));
         sin   = 2'($urandom_range(3));
         pin   = 8'($urandom);
         #1;
         eff   = (m_left > 0) ? m_dir : dir;
         exp_s = eff ? 2'(m_reg % 4) : 2'(m_reg / 64);
         n_checks++; if (sout !== exp_s) begin n_fail++;
            $display("FAIL rnd_sout it=%0d got %b exp %b", i, sout, exp_s); end
         if (m_left > 0) begin
            if (load) begin
               m_reg = pin; m_left = 0; m_done = 0;
            end else begin
               m_reg  = mshift(m_reg, m_dir, m_rot, sin);
               m_left = m_left - 1;
               m_done = (m_left == 0);
            end
         end else begin
            m_done = 0;
            if (load) m_reg = pin;
            else if (start) begin
               if (cnt != 0) begin m_left = int'(cnt); m_dir = dir; m_rot = rot; end
               else m_done = 1;
            end else if (shift) m_reg = mshift(m_reg, dir, rot, sin);
         end
         tick();
         exp_p = m_reg;
         n_checks++; if (pout !== exp_p || busy !== (m_left > 0) || done !== m_done) begin n_fail++;
            $display("FAIL rnd_state it=%0d got pout=%h busy=%b done=%b exp %h %b %b",
                     i, pout, busy, done, exp_p, (m_left > 0), m_done); end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_left_seq();
      test_right_seq();
      test_zero_count();
      test_abort();
      test_reset_mid();
      test_shift_busy();
      test_rotate();
      test_max_count();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sbd_shifter_seq.md
# sbd_shifter_seq

Parametrised, sequenced successor to the fixed 2-bit left shifter used in the square-root datapath. Holds a WIDTH-bit register that shifts STEP bits per cycle in either direction, and runs a multi-cycle shift of a programmed count under a START/BUSY/DONE handshake. Also supports single-step shifting for legacy callers. Sits between the sqrt/divide control FSMs and their operand and remainder registers.

## Interface
- WIDTH, 24, register width; must be > STEP.
- STEP, 2, bits shifted per shift cycle; ≥ 1.
- CNTW, 5, width of the shift-count input.

- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- LOAD  in  1  parallel load of PIN.
- PIN  in  WIDTH  parallel load data.
- SHIFT  in  1  single-step shift, accepted only when not BUSY.
- START  in  1  begin a sequenced shift of CNT steps.
- CNT  in  CNTW  step count, sampled on START.
- DIR  in  1  direction: 0 = left (towards MSB), 1 = right. Sampled on START or SHIFT.
- ROT  in  1  rotate mode; only honoured with SBD_SHIFTER_ROTATE_EN.
- SIN  in  STEP  serial fill bits, sampled on every shift cycle.
- POUT  out  WIDTH  register contents.
- SOUT  out  STEP  bits that exit on the next shift: POUT[WIDTH-1:WIDTH-STEP] if the effective DIR is left, POUT[STEP-1:0] if right. Combinational from the register and the effective DIR.
- BUSY  out  1  sequenced shift in progress.
- DONE  out  1  one-cycle pulse when a sequence completes.

## Operation
- States: IDLE, RUN, FIN. Reset (RST_N low, asynchronous): state IDLE, register 0, remaining count 0, latched DIR 0. POUT=0, SOUT=0, BUSY=0, DONE=0.
- Effective DIR is the latched DIR in RUN, and the DIR input otherwise.
- Left shift: {reg[WIDTH-STEP-1:0], SIN}. Right shift: {SIN, reg[WIDTH-1:STEP]}.
- IDLE and FIN accept commands identically, with priority LOAD > START > SHIFT:
  - LOAD writes PIN.
  - START with CNT=n>0: latch DIR, ROT and n, go to RUN.
  - START with CNT=0: go to FIN with no shift.
  - SHIFT: one shift in the DIR direction, state goes to IDLE.
  - No command: FIN goes to IDLE.
- RUN:
  - Each cycle performs one shift and decrements the count.
  - The cycle that performs the last shift (count was 1) moves to FIN.
  - START and SHIFT are ignored.
  - LOAD aborts: writes PIN, goes to IDLE, no DONE.
- BUSY = (state == RUN). DONE = (state == FIN).
- Count arithmetic is unsigned CNTW-bit. The maximum sequence is 2^CNTW−1 steps. There is no wrap: the count stops at 0.

## Timing
- START accepted at edge 0 with CNT=n: shifts happen at edges 1..n. BUSY is high for cycles 1..n. DONE is high for exactly cycle n+1. A new START at edge n+1 is accepted (back-to-back).
- CNT=0: DONE is high in cycle 1 and BUSY never rises.
- SHIFT in IDLE: POUT updates at the next edge. No BUSY, no DONE.
- SOUT tracks POUT combinationally, with zero latency.
- Reset mid-sequence clears everything immediately, with no DONE.
- LOAD and START in the same idle cycle: the load happens and START is dropped.

## Configuration
- SBD_SHIFTER_ROTATE_EN defined:
  - With ROT=1 (latched on START, live for SHIFT), the exiting STEP bits re-enter at the opposite end and SIN is ignored.
  - Left rotate: {reg[WIDTH-STEP-1:0], reg[WIDTH-1:WIDTH-STEP]}.
  - Right rotate: {reg[STEP-1:0], reg[WIDTH-1:STEP]}.
- Undefined: ROT is ignored and the shifter always fills from SIN. The port remains present.

## Test plan
All scenarios use WIDTH=8, STEP=2, CNTW=5.
1. LOAD 0xA5, then START DIR=0 CNT=2 SIN=2'b01 -> SOUT is 2'b10, 2'b10, 2'b01 across the sequence; POUT goes 0x95 then 0x55; BUSY high for 2 cycles; DONE pulses in cycle 3.
2. LOAD 0xA5, then START DIR=1 CNT=1 SIN=2'b11 -> POUT=0xE9, SOUT before the shift = 2'b01, DONE in cycle 2.
3. START CNT=0 -> DONE in cycle 1, BUSY stays 0, POUT unchanged. START again in the DONE cycle -> accepted.
4. LOAD 0x0F, START DIR=0 CNT=10, then LOAD 0x3C at cycle 3 -> POUT=0x3C, BUSY low next cycle, no DONE.
5. Reset mid-sequence (RST_N low between edges) -> POUT, SOUT, BUSY, DONE all 0 immediately. SHIFT during BUSY -> no extra shift.
6. With SBD_SHIFTER_ROTATE_EN: LOAD 0xA5, START ROT=1 DIR=0 CNT=4 -> POUT=0xA5 at DONE. Right rotate CNT=1 -> 0x69. Without the macro, the same stimulus with SIN=0 -> 0x00.
